// File: rtl/aes_word_loader.sv
// aes_word_loader: packs 32-bit plaintext words into 128-bit AES blocks with a snapshotted key,
// and tracks cipher results with a valid delay line matched to the cipher latency.
module aes_word_loader #(
  parameter int LATENCY = 10,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_data,
  input  logic             key_wr,
  input  logic [1:0]       key_idx,
  input  logic [31:0]      key_word,
  output logic [127:0]     blk_data,
  output logic [127:0]     blk_key,
  output logic             blk_valid,
  output logic             res_valid,
  output logic [4:0]       in_flight,
  output logic [CNT_W-1:0] blk_count,
  output logic             busy
);
  logic [1:0]         word_cnt;
  logic [127:0]       buf_r;
  logic [127:0]       key_reg;
  logic [LATENCY-1:0] dly;
  logic [LATENCY:0]   dly_n;
  logic               accept;
  logic               launch;
  assign s_ready   = en & ~flush;
  assign accept    = s_valid & s_ready;
  assign launch    = accept & (word_cnt == 2'd3);
  assign dly_n     = {dly, blk_valid};
  assign res_valid = dly[LATENCY-1];
  assign busy      = (word_cnt != 2'd0) | (in_flight != 5'd0);
  // word k lands at bits [127-32k -: 32]; ~k*32 is that slice's low bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt  <= '0;
      buf_r     <= '0;
      key_reg   <= '0;
      blk_data  <= '0;
      blk_key   <= '0;
      blk_valid <= 1'b0;
      dly       <= '0;
      in_flight <= '0;
      blk_count <= '0;
    end else begin
      if (flush) begin
        word_cnt <= '0;
        buf_r    <= '0;
      end else if (accept) begin
        word_cnt                     <= word_cnt + 2'd1;
        buf_r[{~word_cnt, 5'd0} +: 32] <= s_data;
      end
      if (key_wr) key_reg[{~key_idx, 5'd0} +: 32] <= key_word;
      if (launch) begin
        blk_data  <= {buf_r[127:32], s_data};
        blk_key   <= key_reg;
        blk_count <= blk_count + CNT_W'(1);
      end
      blk_valid <= launch;
      dly       <= dly_n[LATENCY-1:0];
      in_flight <= in_flight + 5'(blk_valid) - 5'(res_valid);
    end
  end
endmodule
